// File: rtl/latency_ram_if.sv
// latency_ram_if: RAM port bundle between memory_control (master) and latency_ram (slave)
interface latency_ram_if;
    logic        ramren;
    logic        ramwen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    modport master (output ramren, ramwen, ramaddr, ramstore, input ramload, ramstate);
    modport slave (input ramren, ramwen, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/latency_ram.sv
// latency_ram: word-addressed RAM responder with a fixed multi-cycle access latency
module latency_ram #(
    parameter int DEPTH = 1024,
    parameter int LAT = 3
) (
    input logic clk,
    input logic rst,
    latency_ram_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic op_wr;
    logic [29:0] addr_q;
    logic [31:0] mem [DEPTH];
    logic req, illegal, same, latch, commit;
    logic [AW-1:0] idx;
    assign req = bus.ramren | bus.ramwen;
    assign illegal = (bus.ramren & bus.ramwen) | (bus.ramaddr[1:0] != 2'b00) |
                     ({2'b00, bus.ramaddr[31:2]} >= 32'(DEPTH));
    // only an unchanged legal request keeps counting down; anything else re-evaluates as from FREE
    assign same = (state == BUSY) && req && !illegal && (bus.ramwen == op_wr) &&
                  (bus.ramaddr[31:2] == addr_q);
    assign idx = bus.ramaddr[AW+1:2];
    assign bus.ramstate = state;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        latch = 1'b0;
        commit = 1'b0;
        if (same) begin
            state_n = (cnt == 4'd1) ? ACCESS : BUSY;
            cnt_n = cnt - 4'd1;
            commit = (cnt == 4'd1);
        end else if (!req) begin
            state_n = FREE;
        end else if (illegal) begin
            state_n = ERROR;
        end else begin
            latch = 1'b1;
            cnt_n = 4'(LAT - 1);
            state_n = (LAT == 1) ? ACCESS : BUSY;
            commit = (LAT == 1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
            cnt <= 4'd0;
            op_wr <= 1'b0;
            addr_q <= 30'd0;
            bus.ramload <= 32'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (latch) begin
                op_wr <= bus.ramwen;
                addr_q <= bus.ramaddr[31:2];
            end
            if (commit && bus.ramwen) mem[idx] <= bus.ramstore;
            if (commit && !bus.ramwen) bus.ramload <= mem[idx];
        end
    end
endmodule
